// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: each channel synchronises a raw asynchronous
// input, accepts a new level once it has been stable long enough, and pulses rise/fall.

module debounce_lane #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Any cycle of agreement clears the count; only an unbroken run is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            out  <= RESET_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                out  <= s;
                rise <= s;
                fall <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

module debounce_multi #(
    parameter int   N_CHANNELS     = 4,
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_CHANNELS-1:0] in,
    output logic [N_CHANNELS-1:0] out,
    output logic [N_CHANNELS-1:0] rise,
    output logic [N_CHANNELS-1:0] fall,
    output logic                  any_event
);

    genvar i;
    generate
        for (i = 0; i < N_CHANNELS; i++) begin : g_lane
            debounce_lane #(
                .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
                .SYNC_STAGES   (SYNC_STAGES),
                .RESET_LEVEL   (RESET_LEVEL)
            ) u_lane (
                .clock  (clock),
                .reset_n(reset_n),
                .in     (in[i]),
                .out    (out[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate

    // Built only from registered pulses, so no path from in reaches it.
    assign any_event = |{rise, fall};

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: one instance with DEBOUNCE_LIMIT=4, one with DEBOUNCE_LIMIT=1.

module tb_debounce_multi;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic       any_a, any_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    debounce_multi #(.N_CHANNELS(4), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .any_event(any_a)
    );

    debounce_multi #(.N_CHANNELS(4), .DEBOUNCE_LIMIT(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .any_event(any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a);
        chk({tag, ".out"},  32'(out_a),  32'(o));
        chk({tag, ".rise"}, 32'(rise_a), 32'(r));
        chk({tag, ".fall"}, 32'(fall_a), 32'(f));
        chk({tag, ".any"},  32'(any_a),  32'(a));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a);
        chk({tag, ".out"},  32'(out_b),  32'(o));
        chk({tag, ".rise"}, 32'(rise_b), 32'(r));
        chk({tag, ".fall"}, 32'(fall_b), 32'(f));
        chk({tag, ".any"},  32'(any_b),  32'(a));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] bounce;

    initial begin
        reset_n = 1'b0;
        in_a    = 4'hF;
        in_b    = 4'hF;
        #1;

        // Reset holds everything low even with all inputs high.
        for (int k = 0; k < 3; k++) begin
            step();
            chk_a("reset_a", 4'h0, 4'h0, 4'h0, 1'b0);
            chk_b("reset_b", 4'h0, 4'h0, 4'h0, 1'b0);
        end
        in_a = 4'h0;
        in_b = 4'h0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_a("idle", 4'h0, 4'h0, 4'h0, 1'b0);
        end

        // Clean step on channel 0: accepted after edge 6, pulse for one cycle.
        in_a[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       chk_a("step_wait", 4'h0, 4'h0, 4'h0, 1'b0);
            else if (e == 6) chk_a("step_acc",  4'h1, 4'h1, 4'h0, 1'b1);
            else             chk_a("step_post", 4'h1, 4'h0, 4'h0, 1'b0);
        end

        // Bounce on channel 1: 1,1,1,0 never reaches four stable cycles.
        bounce = 4'b0111;
        for (int c = 0; c < 16; c++) begin
            in_a[1] = bounce[c % 4];
            step();
            chk_a("bounce", 4'h1, 4'h0, 4'h0, 1'b0);
        end
        in_a[1] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       chk_a("bounce_wait", 4'h1, 4'h0, 4'h0, 1'b0);
            else if (e == 6) chk_a("bounce_acc",  4'h3, 4'h2, 4'h0, 1'b1);
            else             chk_a("bounce_post", 4'h3, 4'h0, 4'h0, 1'b0);
        end

        // Bring channel 2 high, then drop it for a fall pulse.
        in_a[2] = 1'b1;
        for (int e = 1; e <= 7; e++) step();
        chk_a("ch2_high", 4'h7, 4'h0, 4'h0, 1'b0);
        in_a[2] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       chk_a("fall_wait", 4'h7, 4'h0, 4'h0, 1'b0);
            else if (e == 6) chk_a("fall_acc",  4'h3, 4'h0, 4'h4, 1'b1);
            else             chk_a("fall_post", 4'h3, 4'h0, 4'h0, 1'b0);
        end

        // Simultaneous rise on channel 3 and fall on channel 0.
        in_a[3] = 1'b1;
        in_a[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       chk_a("simul_wait", 4'h3, 4'h0, 4'h0, 1'b0);
            else if (e == 6) chk_a("simul_acc",  4'hA, 4'h8, 4'h1, 1'b1);
            else             chk_a("simul_post", 4'hA, 4'h0, 4'h0, 1'b0);
        end

        // Reset mid-count on channel 2: count and levels discarded, no pulse.
        in_a[2] = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        chk_a("pend", 4'hA, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_a("mid_reset", 4'h0, 4'h0, 4'h0, 1'b0);
        step();
        step();
        chk_a("mid_reset_hold", 4'h0, 4'h0, 4'h0, 1'b0);
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       chk_a("rel_wait", 4'h0, 4'h0, 4'h0, 1'b0);
            else if (e == 6) chk_a("rel_acc",  4'hE, 4'hE, 4'h0, 1'b1);
            else             chk_a("rel_post", 4'hE, 4'h0, 4'h0, 1'b0);
        end

        // DEBOUNCE_LIMIT=1: a pending change cut by reset, then accepted after 3 edges.
        in_b = 4'h5;
        step();
        reset_n = 1'b0;
        #1;
        chk_b("b_reset", 4'h0, 4'h0, 4'h0, 1'b0);
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e < 3)       chk_b("b_wait", 4'h0, 4'h0, 4'h0, 1'b0);
            else if (e == 3) chk_b("b_acc",  4'h5, 4'h5, 4'h0, 1'b1);
            else             chk_b("b_post", 4'h5, 4'h0, 4'h0, 1'b0);
        end
        in_b = 4'h0;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e < 3)       chk_b("b_fwait", 4'h5, 4'h0, 4'h0, 1'b0);
            else if (e == 3) chk_b("b_facc",  4'h0, 4'h0, 4'h5, 1'b1);
            else             chk_b("b_fpost", 4'h0, 4'h0, 4'h0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
